alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  rising-edge clock for the registered result copy.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 rs1  input  32  operand A (register rs1 or PC, selected upstream).
REQ-004 rs2  input  32  operand B (register rs2 or immediate, selected upstream).
REQ-005 ALUsel  input  4  operation select; encodings per REQ-010.
REQ-006 alu_res  output  32  combinational result of the selected operation.
REQ-007 alu_res_q  output  32  alu_res registered on rising clk edge.
REQ-008 zero  output  1  combinational; 1 when alu_res == 32'h0.
REQ-009 Parameters: none; width fixed at 32.

Function
REQ-010 ALUsel encodings are fixed: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, JADD=10, LUIOP=11; 12-15 reserved.
REQ-011 ADD: rs1 + rs2 modulo 2^32; carry discarded.
REQ-012 SUB: rs1 - rs2 modulo 2^32; borrow discarded.
REQ-013 SLL: rs1 shifted left by rs2[4:0]; rs2[31:5] ignored; zero fill.
REQ-014 SRL: rs1 shifted right logically by rs2[4:0]; zero fill.
REQ-015 SRA: rs1 shifted right arithmetically by rs2[4:0]; fill with rs1[31].
REQ-016 SLT: 32'd1 if signed(rs1) < signed(rs2), else 32'd0.
REQ-017 SLTU: 32'd1 if unsigned rs1 < unsigned rs2, else 32'd0.
REQ-018 XOR, OR, AND: bitwise on rs1 and rs2.
REQ-019 JADD: (rs1 + rs2) with bit 0 forced to 0 (jump target for JAL/JALR).
REQ-020 LUIOP: alu_res = rs2 (pass-through of the U-type immediate); rs1 ignored.
REQ-021 Reserved codes 12-15: alu_res = 32'h0.
REQ-022 alu_res and zero are purely combinational; zero latency; no latches; no dependence on clk or reset.
REQ-023 alu_res_q takes alu_res on every rising clk edge when reset is low; one-cycle latency; no enable.
REQ-024 Shift by 0 returns rs1 unchanged for SLL, SRL and SRA.
REQ-025 Boundary results are fixed: SLT of 0x80000000 vs 0x00000001 = 1; SLTU of the same pair = 0; equal operands give 0 for both compares.

Reset
REQ-026 While reset is high, alu_res_q = 32'h0 immediately, independent of clk.
REQ-027 On reset deassertion, alu_res_q updates at the next rising clk edge.
REQ-028 reset does not affect alu_res or zero.

Structure
REQ-029 The ALUsel encodings of REQ-010 belong in the shared package alu_pkg and are used by both alu and the execute stage control decode.
REQ-030 Shifting is implemented in one sub-module, alu_shifter: inputs data[32], shamt[5], mode (SLL/SRL/SRA); output 32-bit result.
REQ-031 All other operations are implemented inline in alu.

Verification
REQ-032 ADD rs1=0xFFFFFFFF, rs2=0x00000001 -> alu_res=0x00000000, zero=1; SUB rs1=0, rs2=1 -> 0xFFFFFFFF, zero=0.
REQ-033 Shifts with rs1=0x80000001, rs2=0x00000024 (shamt 4): SLL -> 0x00000010; SRL -> 0x08000000; SRA -> 0xF8000000.
REQ-034 Compares with rs1=0x80000000, rs2=0x00000001: SLT -> 1; SLTU -> 0.
REQ-035 JADD rs1=0x00001001, rs2=0x00000004 -> 0x00001004; LUIOP rs1=0x1234, rs2=0xABCDE000 -> 0xABCDE000; ALUsel=13 -> 0.
REQ-036 Register path: ADD 5+7 with clk running -> alu_res_q=12 one edge later; assert reset mid-cycle -> alu_res_q=0 before the next edge while alu_res stays 12.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings (also consumed by the execute-stage
// control decode), shifter modes and small helpers.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_JADD  = 4'd10,
        ALU_LUIOP = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_mode_e;

    // Left shifts reuse the right-shift datapath by mirroring the word.
    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

    function automatic shift_mode_e shift_mode_of(input logic [3:0] op);
        shift_mode_e m;
        case (op)
            ALU_SLL: m = SHIFT_SLL;
            ALU_SRA: m = SHIFT_SRA;
            default: m = SHIFT_SRL;
        endcase
        return m;
    endfunction

    function automatic logic is_zero(input logic [XLEN-1:0] v);
        return (v == {XLEN{1'b0}});
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage (master) and the ALU (slave).
interface alu_if;
    import alu_pkg::*;

    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [3:0]      ALUsel;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] alu_res_q;
    logic            zero;

    modport master (
        output rs1,
        output rs2,
        output ALUsel,
        input  alu_res,
        input  alu_res_q,
        input  zero
    );

    modport slave (
        input  rs1,
        input  rs2,
        input  ALUsel,
        output alu_res,
        output alu_res_q,
        output zero
    );
endinterface

// File: rtl/alu_shifter.sv
// Five-stage logarithmic right shifter; SLL is done by mirroring in and out,
// SRA by feeding the sign bit as fill.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  shift_mode_e     mode,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] pre_s;
    logic            fill_s;
    logic [XLEN-1:0] st0_s;
    logic [XLEN-1:0] st1_s;
    logic [XLEN-1:0] st2_s;
    logic [XLEN-1:0] st3_s;
    logic [XLEN-1:0] st4_s;

    // Select the pre-shift word and the fill bit for the chosen mode.
    always_comb begin
        pre_s  = {XLEN{1'b0}};
        fill_s = 1'b0;
        case (mode)
            SHIFT_SLL: begin
                pre_s  = bit_reverse(data);
                fill_s = 1'b0;
            end
            SHIFT_SRL: begin
                pre_s  = data;
                fill_s = 1'b0;
            end
            SHIFT_SRA: begin
                pre_s  = data;
                fill_s = data[XLEN-1];
            end
            default: begin
                pre_s  = {XLEN{1'b0}};
                fill_s = 1'b0;
            end
        endcase
    end

    assign st0_s = shamt[0] ? {fill_s,        pre_s[XLEN-1:1]}  : pre_s;
    assign st1_s = shamt[1] ? {{2{fill_s}},   st0_s[XLEN-1:2]}  : st0_s;
    assign st2_s = shamt[2] ? {{4{fill_s}},   st1_s[XLEN-1:4]}  : st1_s;
    assign st3_s = shamt[3] ? {{8{fill_s}},   st2_s[XLEN-1:8]}  : st2_s;
    assign st4_s = shamt[4] ? {{16{fill_s}},  st3_s[XLEN-1:16]} : st3_s;

    // Undo the mirroring for left shifts.
    always_comb begin
        if (mode == SHIFT_SLL) begin
            result = bit_reverse(st4_s);
        end else begin
            result = st4_s;
        end
    end

endmodule

// File: rtl/alu.sv
// RV32I ALU: combinational result and zero flag plus a registered copy of the
// result; reset clears only the registered copy.
module alu
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    alu_if.slave   bus
);

    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] diff_s;
    logic [XLEN-1:0] shift_res_s;
    logic            slt_s;
    logic            sltu_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] alu_res_d;
    logic [XLEN-1:0] alu_res_q;

    assign sum_s  = bus.rs1 + bus.rs2;
    assign diff_s = bus.rs1 - bus.rs2;
    assign slt_s  = ($signed(bus.rs1) < $signed(bus.rs2));
    assign sltu_s = (bus.rs1 < bus.rs2);

    alu_shifter u_shifter (
        .data   (bus.rs1),
        .shamt  (bus.rs2[4:0]),
        .mode   (shift_mode_of(bus.ALUsel)),
        .result (shift_res_s)
    );

    // Result multiplexer; reserved encodings yield zero.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (bus.ALUsel)
            ALU_ADD:   alu_res_s = sum_s;
            ALU_SUB:   alu_res_s = diff_s;
            ALU_SLL:   alu_res_s = shift_res_s;
            ALU_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, slt_s};
            ALU_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, sltu_s};
            ALU_XOR:   alu_res_s = bus.rs1 ^ bus.rs2;
            ALU_SRL:   alu_res_s = shift_res_s;
            ALU_SRA:   alu_res_s = shift_res_s;
            ALU_OR:    alu_res_s = bus.rs1 | bus.rs2;
            ALU_AND:   alu_res_s = bus.rs1 & bus.rs2;
            ALU_JADD:  alu_res_s = {sum_s[XLEN-1:1], 1'b0};
            ALU_LUIOP: alu_res_s = bus.rs2;
            default:   alu_res_s = {XLEN{1'b0}};
        endcase
    end

    assign alu_res_d = alu_res_s;

    // Registered copy of the result, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_res_q <= {XLEN{1'b0}};
        end else begin
            alu_res_q <= alu_res_d;
        end
    end

    assign bus.alu_res   = alu_res_s;
    assign bus.zero      = is_zero(alu_res_s);
    assign bus.alu_res_q = alu_res_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary vectors and random vectors
// compared against an arithmetic reference model.
module tb_alu;

    logic clk;
    logic reset;
    int   n_vectors;
    int   n_miscompares;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint signed sa;
        longint signed sb;
        sh = b % 32;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return 32'(sa >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return (a + b) & 32'hFFFF_FFFE;
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one vector mid-cycle, check combinational outputs, then the register.
    task automatic apply(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        @(negedge clk);
        bus.ALUsel = 4'(op);
        bus.rs1    = a;
        bus.rs2    = b;
        exp = ref_alu(op, a, b);
        #1;
        check({tag, ".res"},  bus.alu_res, exp);
        check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
        @(posedge clk);
        #1;
        check({tag, ".q"}, bus.alu_res_q, exp);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset      = 1'b1;
        bus.rs1    = 32'd0;
        bus.rs2    = 32'd0;
        bus.ALUsel = 4'd0;

        #2;
        check("reset_q_async", bus.alu_res_q, 32'd0);
        @(posedge clk);
        #1;
        check("reset_q_held", bus.alu_res_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        apply("add_wrap",  0,  32'hFFFF_FFFF, 32'h0000_0001);
        apply("sub_wrap",  1,  32'h0000_0000, 32'h0000_0001);
        apply("sll4",      2,  32'h8000_0001, 32'h0000_0024);
        apply("srl4",      6,  32'h8000_0001, 32'h0000_0024);
        apply("sra4",      7,  32'h8000_0001, 32'h0000_0024);
        apply("sll0",      2,  32'hDEAD_BEEF, 32'h0000_0020);
        apply("srl0",      6,  32'hDEAD_BEEF, 32'h0000_0000);
        apply("sra0",      7,  32'hDEAD_BEEF, 32'hFFFF_FFE0);
        apply("sra31",     7,  32'h8000_0000, 32'h0000_001F);
        apply("slt_min",   3,  32'h8000_0000, 32'h0000_0001);
        apply("sltu_min",  4,  32'h8000_0000, 32'h0000_0001);
        apply("slt_eq",    3,  32'h1234_5678, 32'h1234_5678);
        apply("sltu_eq",   4,  32'h1234_5678, 32'h1234_5678);
        apply("jadd",      10, 32'h0000_1001, 32'h0000_0004);
        apply("luiop",     11, 32'h0000_1234, 32'hABCD_E000);
        apply("rsv13",     13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Registered path and asynchronous reset mid-cycle.
        apply("add_5_7", 0, 32'd5, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_q",   bus.alu_res_q, 32'd0);
        check("mid_reset_res", bus.alu_res,   32'd12);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_q_wait", bus.alu_res_q, 32'd0);
        @(posedge clk);
        #1;
        check("post_reset_q", bus.alu_res_q, 32'd12);

        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] a;
            logic [31:0] b;
            op = int'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = a;
                1:       a = a | 32'h8000_0000;
                2:       b = b & 32'h0000_001F;
                default: b = b;
            endcase
            apply($sformatf("rnd%0d_op%0d", i, op), op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
